// File: rtl/uart_rx_frame_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receive frame controller:
//   - FSM state encoding used by uart_rx_frame_ctrl
//   - default frame start marker (SYNC byte)
//   - UART bit timing constant and the inter-byte timeout derived from it
//   - frame checksum helper
// -----------------------------------------------------------------------------
package uart_pkg;

  // Clocks per UART bit and bits per character (start + 8 data + stop).
  localparam int CLK_PER_BIT   = 434;
  localparam int BITS_PER_BYTE = 10;

  // Three character times of silence inside a frame abort it.
  localparam int DEFAULT_TIMEOUT_CYC = 3 * BITS_PER_BYTE * CLK_PER_BIT;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'h55;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_GET_ADDR = 2'd1,
    ST_GET_DATA = 2'd2,
    ST_GET_CHK  = 2'd3
  } state_e;

  // A frame is good when its check byte equals ADDR xor DATA.
  function automatic logic chk_ok(input logic [7:0] addr,
                                  input logic [7:0] data,
                                  input logic [7:0] chk);
    return chk == (addr ^ data);
  endfunction

endpackage

// File: rtl/uart_rx_frame_ctrl_if.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl_if
// Bundles the byte input from the UART receiver and the register-write /
// status outputs of the frame controller.
//   rx_irq, rx_data      : byte-valid pulse and received byte (into controller)
//   wr_en, wr_addr,
//   wr_data              : register write strobe and last good frame contents
//   err_chk, err_timeout : error pulses
//   busy, frame_cnt      : frame in progress, good frame count
// master : side that supplies bytes and observes results
// slave  : the frame controller
// -----------------------------------------------------------------------------
interface uart_rx_frame_ctrl_if;

  logic       rx_irq;
  logic [7:0] rx_data;
  logic       wr_en;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       err_chk;
  logic       err_timeout;
  logic       busy;
  logic [7:0] frame_cnt;

  modport master (
    output rx_irq, rx_data,
    input  wr_en, wr_addr, wr_data, err_chk, err_timeout, busy, frame_cnt
  );

  modport slave (
    input  rx_irq, rx_data,
    output wr_en, wr_addr, wr_data, err_chk, err_timeout, busy, frame_cnt
  );

endinterface

// File: rtl/uart_rx_frame_ctrl_byte_timer.sv
// -----------------------------------------------------------------------------
// uart_byte_timer
// Inter-byte idle timer. Counts clocks while enabled, clears on request, and
// saturates at TIMEOUT_CYC-1 so it can never wrap back into a false quiet
// period.
//   clk : system clock
//   rst : asynchronous active-low reset
//   clr : clear counter to 0 (wins over en)
//   en  : count this clock
//   tc  : counter is at its terminal value TIMEOUT_CYC-1
// -----------------------------------------------------------------------------
module uart_byte_timer
  import uart_pkg::*;
#(
  parameter int TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != TC_VAL)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = (cnt_q == TC_VAL);

endmodule

// File: rtl/uart_rx_frame_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_frame_ctrl
// Assembles 4-byte frames {SYNC, ADDR, DATA, CHK} from a UART byte stream and
// turns each good frame into a one-cycle register write.
//   clk : system clock, all logic on posedge
//   rst : asynchronous active-low reset
//   bus : uart_rx_frame_ctrl_if.slave
//         in : rx_irq, rx_data
//         out: wr_en, wr_addr, wr_data (registered write strobe + contents)
//              err_chk (bad checksum pulse), err_timeout (inter-byte timeout
//              pulse), busy (frame in progress), frame_cnt (good frames)
// -----------------------------------------------------------------------------
module uart_rx_frame_ctrl
  import uart_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT_CYC = DEFAULT_TIMEOUT_CYC
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_rx_frame_ctrl_if.slave  bus
);

  state_e     state_q,     state_d;
  logic [7:0] addr_q,      addr_d;
  logic [7:0] data_q,      data_d;
  logic       wr_en_q,     wr_en_d;
  logic [7:0] wr_addr_q,   wr_addr_d;
  logic [7:0] wr_data_q,   wr_data_d;
  logic       err_chk_q,   err_chk_d;
  logic       err_to_q,    err_to_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;

  logic timer_clr;
  logic timer_en;
  logic timer_tc;

  uart_byte_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_timer (
    .clk (clk),
    .rst (rst),
    .clr (timer_clr),
    .en  (timer_en),
    .tc  (timer_tc)
  );

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    err_chk_d   = 1'b0;
    err_to_d    = 1'b0;
    frame_cnt_d = frame_cnt_q;

    // A byte arriving on the terminal-count cycle is accepted, so the byte
    // path is checked before the timeout path.
    if (bus.rx_irq) begin
      unique case (state_q)
        ST_IDLE: begin
          if (bus.rx_data == SYNC_BYTE) begin
            state_d = ST_GET_ADDR;
          end
        end
        ST_GET_ADDR: begin
          addr_d  = bus.rx_data;
          state_d = ST_GET_DATA;
        end
        ST_GET_DATA: begin
          data_d  = bus.rx_data;
          state_d = ST_GET_CHK;
        end
        ST_GET_CHK: begin
          state_d = ST_IDLE;
          if (chk_ok(addr_q, data_q, bus.rx_data)) begin
            wr_en_d     = 1'b1;
            wr_addr_d   = addr_q;
            wr_data_d   = data_q;
            frame_cnt_d = frame_cnt_q + 8'd1;
          end else begin
            err_chk_d = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (timer_tc && (state_q != ST_IDLE)) begin
      state_d  = ST_IDLE;
      err_to_d = 1'b1;
    end

    // Clearing on every byte also covers the SYNC that starts a frame; the
    // counter is held at zero throughout IDLE.
    timer_clr = bus.rx_irq || (state_d == ST_IDLE);
    timer_en  = (state_q != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      err_chk_q   <= 1'b0;
      err_to_q    <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      err_chk_q   <= err_chk_d;
      err_to_q    <= err_to_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  assign bus.wr_en       = wr_en_q;
  assign bus.wr_addr     = wr_addr_q;
  assign bus.wr_data     = wr_data_q;
  assign bus.err_chk     = err_chk_q;
  assign bus.err_timeout = err_to_q;
  assign bus.frame_cnt   = frame_cnt_q;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule
